// File: rtl/rotate_pkg.sv
// Shared definitions for the rotator's frame-reader slice: pixel and frame
// limits, the reader FSM state type and a geometry helper.
package rotate_pkg;

  localparam int PIX_W        = 24;
  localparam int MAX_W        = 1280;
  localparam int MAX_H        = 720;
  // Smallest word address width that covers one maximum-size frame.
  localparam int FRAME_ADDR_W = $clog2(MAX_W * MAX_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // A frame is only worth starting when both dimensions are nonzero.
  function automatic logic geom_ok(input logic [11:0] w, input logic [10:0] h);
    return (w != 12'd0) && (h != 11'd0);
  endfunction

endpackage

// File: rtl/rotate_frame_reader_if.sv
// Bus bundle between the frame reader, its frame memory and the rotator's
// write side.
//
// Handshake semantics: mem_rd_en is a one-cycle read strobe for mem_addr; the
// memory returns mem_rdata a fixed number of cycles later with no handshake.
// valid_o/data_o form a push-only stream (no per-pixel ready). wr_ready is a
// frame-level ready: it is looked at only when a frame is about to start and
// is ignored while a frame is streaming.
interface rotate_frame_reader_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 21
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_ready;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;

  modport master (
    output mem_rd_en, mem_addr, valid_o, data_o,
    input  mem_rdata, wr_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, valid_o, data_o,
    output mem_rdata, wr_ready
  );

endinterface

// File: rtl/rotate_rd_delay.sv
// RD_LAT-deep shift register that carries {valid, last} alongside a memory
// read so both arrive together with the read data.
module rotate_rd_delay #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [RD_LAT-1:0] v_sr;
  logic [RD_LAT-1:0] l_sr;

  // Shift the read tags one stage per cycle; reset discards in-flight reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr[0] <= in_valid;
      l_sr[0] <= in_last;
      for (int i = 1; i < RD_LAT; i++) begin
        v_sr[i] <= v_sr[i-1];
        l_sr[i] <= l_sr[i-1];
      end
    end
  end

  assign out_valid = v_sr[RD_LAT-1];
  assign out_last  = l_sr[RD_LAT-1];

endmodule

// File: rtl/rotate_frame_reader.sv
// Frame reader: streams one frame from a synchronous-read frame memory in
// raster order into the rotator, with optional blanking after each line.
module rotate_frame_reader
  import rotate_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int ADDR_W = 21,
  parameter int RD_LAT = 2,
  parameter int H_GAP  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [11:0]           img_width,
  input  logic [10:0]           img_height,
  rotate_frame_reader_if.master bus,
  output logic                  busy,
  output logic                  frame_done,
  output state_t                state_dbg
);

  localparam logic [7:0] GAP_LAST = (H_GAP > 0) ? 8'(H_GAP - 1) : 8'd0;

  state_t            state_q, state_d;
  logic [11:0]       width_q, x_cnt;
  logic [10:0]       height_q, y_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        gap_cnt;
  logic [2:0]        drain_cnt;
  logic              start_ok, line_end, last_line, gap_end, drain_end;
  logic              load_frame, rd_en, rd_last;
  logic              tail_valid, tail_last;

  assign start_ok  = enable && bus.wr_ready && geom_ok(img_width, img_height);
  assign line_end  = (x_cnt == width_q - 12'd1);
  assign last_line = (y_cnt == height_q - 11'd1);
  assign gap_end   = (gap_cnt == GAP_LAST);
  assign drain_end = (drain_cnt == 3'(RD_LAT));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    rd_en      = 1'b0;
    rd_last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          load_frame = 1'b1;
          state_d    = LINE;
        end
      end
      LINE: begin
        rd_en = 1'b1;
        if (line_end) begin
          if (last_line) begin
            rd_last = 1'b1;
            state_d = DRAIN;
          end else if (H_GAP > 0) begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_end) state_d = LINE;
      end
      DRAIN: begin
        if (drain_end) begin
          if (start_ok) begin
            load_frame = 1'b1;
            state_d    = LINE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Geometry latch, raster counters and the incrementing read address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      width_q  <= '0;
      height_q <= '0;
      rd_addr  <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
    end else if (load_frame) begin
      width_q  <= img_width;
      height_q <= img_height;
      rd_addr  <= base_addr;
      x_cnt    <= '0;
      y_cnt    <= '0;
    end else if (rd_en) begin
      rd_addr <= rd_addr + 1'b1;
      if (line_end) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 11'd1;
      end else begin
        x_cnt <= x_cnt + 12'd1;
      end
    end
  end

  // Blanking and drain timers, plus the frame busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      gap_cnt   <= (state_q == GAP)   ? gap_cnt + 8'd1   : 8'd0;
      drain_cnt <= (state_q == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      if (load_frame)                         busy <= 1'b1;
      else if (state_q == DRAIN && drain_end) busy <= 1'b0;
    end
  end

  rotate_rd_delay #(.RD_LAT(RD_LAT)) u_rd_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_en),
    .in_last   (rd_last),
    .out_valid (tail_valid),
    .out_last  (tail_last)
  );

  // Output register: capture memory data as its tag leaves the delay line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      frame_done  <= 1'b0;
    end else begin
      bus.valid_o <= tail_valid;
      frame_done  <= tail_valid & tail_last;
      if (tail_valid) bus.data_o <= bus.mem_rdata;
    end
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_addr;
  assign state_dbg     = state_q;

endmodule
